// File: rtl/hdmi_timing_gen.sv
// hdmi_timing_gen: raster timing generator for the HDMI_* display-driver
// interface, plus a re-timing stage that lines the driver's pixel output up
// with delayed copies of DE/HSYNC/VSYNC for the external transmitter.
// Single clock domain (clk_hdmi), asynchronous active-high reset.
module hdmi_timing_gen #(
    parameter int          H_ACTIVE    = 640,
    parameter int          H_FP        = 16,
    parameter int          H_SYNC      = 96,
    parameter int          H_BP        = 48,
    parameter int          V_ACTIVE    = 480,
    parameter int          V_FP        = 10,
    parameter int          V_SYNC      = 2,
    parameter int          V_BP        = 33,
    parameter int          PIX_LATENCY = 0,
    parameter logic [23:0] BLANK_DATA  = 24'h000000
) (
    input  logic        clk_hdmi,
    input  logic        rst,
    output logic        HDMI_DE,
    output logic        HDMI_HSYNC,
    output logic        HDMI_VSYNC,
    input  logic [23:0] pix_in,
    output logic        tx_de,
    output logic        tx_hs,
    output logic        tx_vs,
    output logic [23:0] tx_d,
    output logic [9:0]  h_count,
    output logic [9:0]  v_count,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // 10-bit copies of the raster boundaries so every compare is same-width.
    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0] H_SYNC_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_SYNC_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC);

    // {DE, HS, VS} value held by every sync register while in reset.
    localparam logic [2:0] SYNC_IDLE = 3'b011;

    logic [9:0]  h_q, h_d;
    logic [9:0]  v_q, v_d;
    logic        de_q, de_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        fs_q, fs_d;
    logic [2:0]  sync_dly;          // {DE,HS,VS} as it was PIX_LATENCY clocks ago
    logic        tx_de_q, tx_hs_q, tx_vs_q;
    logic [23:0] tx_d_q;

    // Next raster position plus the timing outputs decoded from that position,
    // so the registered outputs always match the counters shown in the same cycle.
    always_comb begin
        h_d = h_q + 10'd1;
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = 10'd0;
            v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
        end
        de_d = (h_d < H_ACT) && (v_d < V_ACT);
        hs_d = !((h_d >= H_SYNC_BEG) && (h_d < H_SYNC_END));
        vs_d = !((v_d >= V_SYNC_BEG) && (v_d < V_SYNC_END));
        fs_d = (h_d == 10'd0) && (v_d == 10'd0);
    end

    // Raster counters and timing outputs; reset parks on the last back-porch
    // position so the first clock after release lands on (0,0).
    always_ff @(posedge clk_hdmi or posedge rst) begin
        if (rst) begin
            h_q  <= H_LAST;
            v_q  <= V_LAST;
            de_q <= 1'b0;
            hs_q <= 1'b1;
            vs_q <= 1'b1;
            fs_q <= 1'b0;
        end else begin
            h_q  <= h_d;
            v_q  <= v_d;
            de_q <= de_d;
            hs_q <= hs_d;
            vs_q <= vs_d;
            fs_q <= fs_d;
        end
    end

    // Delay line matching the display driver's pixel latency; a zero-latency
    // source uses the timing outputs directly.
    generate
        if (PIX_LATENCY == 0) begin : g_no_dly
            assign sync_dly = {de_q, hs_q, vs_q};
        end else begin : g_dly
            logic [2:0] dly_q [PIX_LATENCY];

            // Shift {DE,HS,VS} one stage per clock; stage k is k+1 clocks old.
            always_ff @(posedge clk_hdmi or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < PIX_LATENCY; k++) begin
                        dly_q[k] <= SYNC_IDLE;
                    end
                end else begin
                    dly_q[0] <= {de_q, hs_q, vs_q};
                    for (int k = 1; k < PIX_LATENCY; k++) begin
                        dly_q[k] <= dly_q[k-1];
                    end
                end
            end

            assign sync_dly = dly_q[PIX_LATENCY-1];
        end
    endgenerate

    // Transmitter register: pixel data is only let through while the delayed
    // DE is high, so anything the driver presents during blanking is dropped.
    always_ff @(posedge clk_hdmi or posedge rst) begin
        if (rst) begin
            tx_de_q <= 1'b0;
            tx_hs_q <= 1'b1;
            tx_vs_q <= 1'b1;
            tx_d_q  <= BLANK_DATA;
        end else begin
            tx_de_q <= sync_dly[2];
            tx_hs_q <= sync_dly[1];
            tx_vs_q <= sync_dly[0];
            tx_d_q  <= sync_dly[2] ? pix_in : BLANK_DATA;
        end
    end

    assign h_count     = h_q;
    assign v_count     = v_q;
    assign HDMI_DE     = de_q;
    assign HDMI_HSYNC  = hs_q;
    assign HDMI_VSYNC  = vs_q;
    assign frame_start = fs_q;
    assign tx_de       = tx_de_q;
    assign tx_hs       = tx_hs_q;
    assign tx_vs       = tx_vs_q;
    assign tx_d        = tx_d_q;

endmodule

// File: tb/tb_hdmi_timing_gen.sv
// tb_hdmi_timing_gen: two instances share clock and reset. dut_def uses the
// default 640x480 timing with a combinational pixel source; dut_sm uses a tiny
// raster with PIX_LATENCY=2 so several whole frames fit in a short run.
// Expected values come from a position-indexed model: p counts clocks since
// reset release, and every output is a closed-form function of p.
module tb_hdmi_timing_gen;

    typedef struct packed {
        int ha; int hfp; int hs; int hbp;
        int va; int vfp; int vs; int vbp;
    } tim_t;

    localparam tim_t T_DEF = '{ha: 640, hfp: 16, hs: 96, hbp: 48,
                               va: 480, vfp: 10, vs: 2,  vbp: 33};
    localparam tim_t T_SM  = '{ha: 16,  hfp: 4,  hs: 6,  hbp: 5,
                               va: 10,  vfp: 2,  vs: 2,  vbp: 3};
    localparam int LAT_DEF = 0;
    localparam int LAT_SM  = 2;
    localparam int SM_FRAME = 31 * 17;

    // ---------------- clock / reset ----------------
    logic clk_hdmi = 1'b0;
    logic rst      = 1'b1;
    always #5 clk_hdmi = ~clk_hdmi;

    // ---------------- DUT wiring ----------------
    logic [23:0] pix_def, pix_sm;
    logic        de_def, hs_def, vs_def, txde_def, txhs_def, txvs_def, fs_def;
    logic        de_sm, hs_sm, vs_sm, txde_sm, txhs_sm, txvs_sm, fs_sm;
    logic [23:0] txd_def, txd_sm;
    logic [9:0]  h_def, v_def, h_sm, v_sm;

    hdmi_timing_gen dut_def (
        .clk_hdmi(clk_hdmi), .rst(rst),
        .HDMI_DE(de_def), .HDMI_HSYNC(hs_def), .HDMI_VSYNC(vs_def),
        .pix_in(pix_def),
        .tx_de(txde_def), .tx_hs(txhs_def), .tx_vs(txvs_def), .tx_d(txd_def),
        .h_count(h_def), .v_count(v_def), .frame_start(fs_def)
    );

    hdmi_timing_gen #(
        .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(5),
        .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .PIX_LATENCY(LAT_SM), .BLANK_DATA(24'h000000)
    ) dut_sm (
        .clk_hdmi(clk_hdmi), .rst(rst),
        .HDMI_DE(de_sm), .HDMI_HSYNC(hs_sm), .HDMI_VSYNC(vs_sm),
        .pix_in(pix_sm),
        .tx_de(txde_sm), .tx_hs(txhs_sm), .tx_vs(txvs_sm), .tx_d(txd_sm),
        .h_count(h_sm), .v_count(v_sm), .frame_start(fs_sm)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;
    int p        = -1;     // raster position since release; -1 while in reset

    // frame-level bookkeeping for dut_sm
    int last_fs_sm = -1;
    int de_frame_sm = 0;
    // line-level bookkeeping for dut_def
    bit line_valid = 1'b0;
    int de_line = 0;
    int hs_line = 0;
    int hs_start = -1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (p=%0d, t=%0t)", tag, obs, exp, p, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int h_total(input tim_t t);
        return t.ha + t.hfp + t.hs + t.hbp;
    endfunction

    function automatic int v_total(input tim_t t);
        return t.va + t.vfp + t.vs + t.vbp;
    endfunction

    function automatic int h_at(input tim_t t, input int q);
        if (q < 0) return h_total(t) - 1;
        return q % h_total(t);
    endfunction

    function automatic int v_at(input tim_t t, input int q);
        if (q < 0) return v_total(t) - 1;
        return (q / h_total(t)) % v_total(t);
    endfunction

    // {DE, HSYNC, VSYNC} at raster position q (negative q = reset position)
    function automatic logic [2:0] sig_at(input tim_t t, input int q);
        int h;
        int v;
        logic de, hs, vs;
        h  = h_at(t, q);
        v  = v_at(t, q);
        de = (h < t.ha) && (v < t.va);
        hs = !((h >= t.ha + t.hfp) && (h < t.ha + t.hfp + t.hs));
        vs = !((v >= t.va + t.vfp) && (v < t.va + t.vfp + t.vs));
        return {de, hs, vs};
    endfunction

    task automatic check_dut(input string pfx, input tim_t t, input int lat,
                             input logic [9:0] h, input logic [9:0] v,
                             input logic de, input logic hs, input logic vs, input logic fs,
                             input logic txde, input logic txhs, input logic txvs,
                             input logic [23:0] txd, input logic [23:0] pix);
        logic [2:0] s;
        logic [2:0] sd;
        logic       fs_exp;
        s  = sig_at(t, p);
        sd = sig_at(t, p - (lat + 1));
        fs_exp = (p >= 0) && (h_at(t, p) == 0) && (v_at(t, p) == 0);
        check_eq({pfx, "_h"},     32'(h),    32'(h_at(t, p)));
        check_eq({pfx, "_v"},     32'(v),    32'(v_at(t, p)));
        check_eq({pfx, "_de"},    32'(de),   32'(s[2]));
        check_eq({pfx, "_hs"},    32'(hs),   32'(s[1]));
        check_eq({pfx, "_vs"},    32'(vs),   32'(s[0]));
        check_eq({pfx, "_fs"},    32'(fs),   32'(fs_exp));
        check_eq({pfx, "_tx_de"}, 32'(txde), 32'(sd[2]));
        check_eq({pfx, "_tx_hs"}, 32'(txhs), 32'(sd[1]));
        check_eq({pfx, "_tx_vs"}, 32'(txvs), 32'(sd[0]));
        check_eq({pfx, "_tx_d"},  32'(txd),  (p >= 0 && sd[2]) ? 32'(pix) : 32'h0);
    endtask

    task automatic check_all();
        check_dut("def", T_DEF, LAT_DEF, h_def, v_def, de_def, hs_def, vs_def, fs_def,
                  txde_def, txhs_def, txvs_def, txd_def, pix_def);
        check_dut("sm", T_SM, LAT_SM, h_sm, v_sm, de_sm, hs_sm, vs_sm, fs_sm,
                  txde_sm, txhs_sm, txvs_sm, txd_sm, pix_sm);
    endtask

    // Aggregate checks from observed outputs: frame cadence and DE count on
    // the small raster, DE/HSYNC run lengths per line on the default raster.
    task automatic check_aggregates();
        if (p < 0) return;
        if (fs_sm) begin
            if (last_fs_sm >= 0) begin
                check_eq("sm_frame_period", 32'(p - last_fs_sm), 32'(SM_FRAME));
                check_eq("sm_de_per_frame", 32'(de_frame_sm), 32'(T_SM.ha * T_SM.va));
            end
            last_fs_sm  = p;
            de_frame_sm = 0;
        end
        if (de_sm) de_frame_sm++;

        if (h_def == 10'd0) begin
            if (line_valid) begin
                check_eq("def_de_per_line", 32'(de_line), 32'(T_DEF.ha));
                check_eq("def_hs_width",    32'(hs_line), 32'(T_DEF.hs));
                check_eq("def_hs_start",    32'(hs_start), 32'(T_DEF.ha + T_DEF.hfp));
            end
            line_valid = 1'b1;
            de_line    = 0;
            hs_line    = 0;
            hs_start   = -1;
        end
        if (de_def) de_line++;
        if (!hs_def) begin
            if (hs_line == 0) hs_start = int'(h_def);
            hs_line++;
        end
    endtask

    // ---------------- driver tasks ----------------
    function automatic logic [23:0] rand_pix();
        if ($urandom_range(0, 3) == 0) return 24'hFFFFFF;
        return 24'($urandom);
    endfunction

    task automatic run_cycles(input int n);
        repeat (n) begin
            @(posedge clk_hdmi);
            if (rst) p = -1;
            else     p++;
            #1;
            check_all();
            check_aggregates();
            pix_def = rand_pix();
            pix_sm  = rand_pix();
        end
    endtask

    // Asynchronous reset in the middle of a clock period: outputs must fall
    // back to reset values without waiting for an edge.
    task automatic async_reset_pulse();
        @(negedge clk_hdmi);
        #($urandom_range(1, 3));
        rst = 1'b1;
        #1;
        p = -1;
        check_all();
        last_fs_sm  = -1;
        de_frame_sm = 0;
        line_valid  = 1'b0;
        run_cycles(3);
        @(negedge clk_hdmi);
        rst = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        pix_def = 24'h0;
        pix_sm  = 24'h0;
        rst     = 1'b1;
        run_cycles(3);
        @(negedge clk_hdmi);
        rst = 1'b0;

        // first release: >3 small frames, >2 default lines
        run_cycles(1800);

        // mid-frame aborts at random positions, then clean restart
        async_reset_pulse();
        run_cycles(SM_FRAME / 2 + 31 * 3 + $urandom_range(0, 30));
        async_reset_pulse();
        run_cycles(1800);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
